// File: rtl/game_input_pkg.sv
// game_input_pkg: move codes, encoder FSM states and the key-index-to-code mapping
package game_input_pkg;
  localparam logic [2:0] GO_NONE  = 3'd0;
  localparam logic [2:0] GO_UP    = 3'd1;
  localparam logic [2:0] GO_DOWN  = 3'd2;
  localparam logic [2:0] GO_LEFT  = 3'd3;
  localparam logic [2:0] GO_RIGHT = 3'd4;
  typedef enum logic {IDLE, HELD} state_e;
  function automatic int key_code(input int idx, input int num_keys);
    return num_keys - idx;
  endfunction
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stability filter for one active-low key
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic stable_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, press_q, flip;
  // Stable flips on the DEBOUNCE_CYCLES-th consecutive edge that sees a differing level
  always_comb begin
    flip = (sync_q[1] != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (sync_q[1] == stable_q || flip) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      cnt_q <= '0;
      stable_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ~key_n_i};
      cnt_q <= cnt_d;
      stable_q <= stable_q ^ flip;
      press_q <= flip & sync_q[1];
    end
  end
  assign stable_o = stable_q;
  assign press_o = press_q;
endmodule

// File: rtl/key_move_encoder.sv
// key_move_encoder: turns debounced key presses into one-cycle move codes,
// with optional auto-repeat while the active key stays held.
module key_move_encoder
  import game_input_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 7500000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                enable,
  output logic [CODE_W-1:0]   go,
  output logic                go_valid,
  output logic                held
);
  localparam int IW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [NUM_KEYS-1:0] stable, press;
  genvar i;
  for (i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .resetn(resetn),
      .key_n_i(key_n[i]),
      .stable_o(stable[i]),
      .press_o(press[i])
    );
  end
  logic sel_v;
  logic [IW-1:0] sel;
  // Highest index wins; lower simultaneous presses are dropped
  always_comb begin
    sel_v = 1'b0;
    sel = '0;
    for (int j = 0; j < NUM_KEYS; j++)
      if (press[j]) begin
        sel_v = 1'b1;
        sel = IW'(j);
      end
  end
  state_e state_q, state_d;
  logic [IW-1:0] act_q, act_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CODE_W-1:0] go_q, go_d;
  logic go_valid_q, held_q;
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    rcnt_d = rcnt_q;
    go_d = CODE_W'(GO_NONE);
    if (!enable) state_d = IDLE;
    else if (state_q == IDLE) begin
      if (sel_v) begin
        go_d = CODE_W'(key_code(int'(sel), NUM_KEYS));
        act_d = sel;
        rcnt_d = RW'(REPEAT_DELAY);
        state_d = HELD;
      end
    end else if (!stable[act_q]) state_d = IDLE;
    else if (sel_v) begin
      go_d = CODE_W'(key_code(int'(sel), NUM_KEYS));
      act_d = sel;
      rcnt_d = RW'(REPEAT_DELAY);
    end else if (REPEAT_EN != 0) begin
      rcnt_d = rcnt_q - 1'b1;
      if (rcnt_q == RW'(1)) begin
        go_d = CODE_W'(key_code(int'(act_q), NUM_KEYS));
        rcnt_d = RW'(REPEAT_PERIOD);
      end
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      act_q <= '0;
      rcnt_q <= '0;
      go_q <= '0;
      go_valid_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      rcnt_q <= rcnt_d;
      go_q <= go_d;
      go_valid_q <= go_d != '0;
      held_q <= |stable;
    end
  end
  assign go = go_q;
  assign go_valid = go_valid_q;
  assign held = held_q;
endmodule

// File: tb/tb_key_move_encoder.sv
// tb_key_move_encoder: directed scenarios on a plain instance (u0) and an auto-repeat instance (u1);
// expected pulses are queued per instance and matched as they appear.
module tb_key_move_encoder;
  logic clk = 1'b0;
  logic resetn, enable;
  logic [3:0] kn [2];
  logic [2:0] go [2];
  logic gv [2];
  logic hd [2];
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  typedef struct {int cyc; int code;} exp_t;
  exp_t q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_move_encoder #(.NUM_KEYS(4), .CODE_W(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                     .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) u0 (
    .clk(clk), .resetn(resetn), .key_n(kn[0]), .enable(enable),
    .go(go[0]), .go_valid(gv[0]), .held(hd[0]));
  key_move_encoder #(.NUM_KEYS(4), .CODE_W(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                     .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) u1 (
    .clk(clk), .resetn(resetn), .key_n(kn[1]), .enable(enable),
    .go(go[1]), .go_valid(gv[1]), .held(hd[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic upto(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic expect_go(input int d, input int t, input int code);
    q[d].push_back('{t, code});
  endtask

  always @(negedge clk) if (resetn) for (int d = 0; d < 2; d++) begin
    if (go[d] !== 3'd0 || gv[d] !== 1'b0) begin
      chk($sformatf("go_valid%0d", d), 32'(gv[d]), 32'(go[d] != 3'd0));
      if (q[d].size() == 0) chk($sformatf("unexpected_go%0d", d), 32'(go[d]), 0);
      else begin
        exp_t e;
        e = q[d].pop_front();
        chk($sformatf("go_cycle%0d", d), cyc, e.cyc);
        chk($sformatf("go_code%0d", d), 32'(go[d]), e.code);
      end
    end
    if (q[d].size() != 0 && q[d][0].cyc < cyc) begin
      chk($sformatf("missing_go%0d", d), cyc, q[d][0].cyc);
      void'(q[d].pop_front());
    end
  end

  initial begin
    int c, r, t0;
    resetn = 1'b0;
    enable = 1'b1;
    kn[0] = 4'hF;
    kn[1] = 4'hF;
    step(3);
    for (int d = 0; d < 2; d++) begin
      chk("reset_go", 32'(go[d]), 0);
      chk("reset_go_valid", 32'(gv[d]), 0);
      chk("reset_held", 32'(hd[d]), 0);
    end
    resetn = 1'b1;
    step(3);
    // key 0 press, single pulse, held timing on press and release
    kn[0][0] = 1'b0;
    c = cyc;
    expect_go(0, c + 7, 4);
    upto(c + 6);
    chk("held_before_accept", 32'(hd[0]), 0);
    upto(c + 7);
    chk("held_after_accept", 32'(hd[0]), 1);
    upto(c + 20);
    kn[0][0] = 1'b1;
    r = cyc;
    upto(r + 6);
    chk("held_before_release", 32'(hd[0]), 1);
    upto(r + 7);
    chk("held_after_release", 32'(hd[0]), 0);
    step(10);
    // key 2 bouncing with 3-cycle segments, then held low
    for (int k = 0; k < 10; k++) begin
      kn[0][2] = k[0];
      step(3);
    end
    chk("bounce_held", 32'(hd[0]), 0);
    kn[0][2] = 1'b0;
    c = cyc;
    expect_go(0, c + 7, 2);
    step(15);
    kn[0][2] = 1'b1;
    step(12);
    // keys 3 and 1 together: only key 3 reported
    kn[0][3] = 1'b0;
    kn[0][1] = 1'b0;
    c = cyc;
    expect_go(0, c + 7, 1);
    step(20);
    chk("both_held", 32'(hd[0]), 1);
    kn[0] = 4'hF;
    step(12);
    // auto-repeat on key 1; release lands just before the t0+30 repeat
    kn[1][1] = 1'b0;
    c = cyc;
    t0 = c + 7;
    expect_go(1, t0, 3);
    expect_go(1, t0 + 10, 3);
    expect_go(1, t0 + 15, 3);
    expect_go(1, t0 + 20, 3);
    expect_go(1, t0 + 25, 3);
    upto(t0 + 23);
    kn[1][1] = 1'b1;
    step(25);
    // accepted while disabled: no pulse on enable, pulse after re-press
    enable = 1'b0;
    kn[0][3] = 1'b0;
    step(12);
    chk("held_while_disabled", 32'(hd[0]), 1);
    enable = 1'b1;
    step(15);
    kn[0][3] = 1'b1;
    step(12);
    kn[0][3] = 1'b0;
    c = cyc;
    expect_go(0, c + 7, 1);
    step(12);
    kn[0][3] = 1'b1;
    step(12);
    // asynchronous reset during a repeat pulse, key held through reset
    kn[1][3] = 1'b0;
    c = cyc;
    expect_go(1, c + 7, 1);
    expect_go(1, c + 17, 1);
    upto(c + 17);
    chk("repeat_before_reset", 32'(go[1]), 1);
    #1 resetn = 1'b0;
    #1;
    chk("async_reset_go", 32'(go[1]), 0);
    chk("async_reset_go_valid", 32'(gv[1]), 0);
    chk("async_reset_held", 32'(hd[1]), 0);
    step(3);
    resetn = 1'b1;
    r = cyc;
    expect_go(1, r + 7, 1);
    upto(r + 9);
    kn[1][3] = 1'b1;
    step(15);
    for (int d = 0; d < 2; d++) chk($sformatf("pending_pulses%0d", d), q[d].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
